// File: rtl/dma_engineer_arbiter_if.sv
// Bundle of requester-side and DMA-side signals around the weight-fetch arbiter.
// The arbiter connects through the master modport; the surrounding logic
// (layer controllers plus DMA engine) connects through the slave modport.
interface dma_engineer_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH   = 2
);
  localparam int unsigned PACK_WIDTH = NUM_REQ * ADDR_WIDTH;

  logic [NUM_REQ-1:0]    req_vec;
  logic [PACK_WIDTH-1:0] req_start_addr;
  logic [PACK_WIDTH-1:0] req_length;
  logic [NUM_REQ-1:0]    ack_vec;
  logic [NUM_REQ-1:0]    dout_en_vec;
  logic [NUM_REQ-1:0]    dout_eop_vec;
  logic [DATA_WIDTH-1:0] dout;

  logic                  dma_engineer_req;
  logic                  dma_engineer_ack;
  logic [ADDR_WIDTH-1:0] dma_engineer_start_addr;
  logic [ADDR_WIDTH-1:0] dma_engineer_length;
  logic                  dma_engineer_dout_en;
  logic                  dma_engineer_dout_eop;
  logic [DATA_WIDTH-1:0] dma_engineer_dout;

  logic                  busy;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic                  proto_err;

  modport master (
    input  req_vec, req_start_addr, req_length,
    input  dma_engineer_ack, dma_engineer_dout_en, dma_engineer_dout_eop, dma_engineer_dout,
    output ack_vec, dout_en_vec, dout_eop_vec, dout,
    output dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
    output busy, grant_id, beat_cnt, proto_err
  );

  modport slave (
    output req_vec, req_start_addr, req_length,
    output dma_engineer_ack, dma_engineer_dout_en, dma_engineer_dout_eop, dma_engineer_dout,
    input  ack_vec, dout_en_vec, dout_eop_vec, dout,
    input  dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
    input  busy, grant_id, beat_cnt, proto_err
  );
endinterface

// File: rtl/dma_engineer_arbiter.sv
// Round-robin arbiter sharing one DMA engine among NUM_REQ layer controllers.
// The grant is held from request until the end-of-packet beat; data is
// broadcast while valid/eop are steered only to the owner.
module dma_engineer_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH   = 2
) (
  input logic                   clk,
  input logic                   rst,
  dma_engineer_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   rr_ptr, grant_id, winner;
  logic                  found;
  logic [NUM_REQ-1:0]    req_bit;
  int unsigned           cand;
  logic [ADDR_WIDTH-1:0] start_addr, length, beat_cnt;
  logic                  dma_req, proto_err;
  logic [NUM_REQ-1:0]    owner_oh;
  logic [NUM_REQ-1:0]    ack_vec_c, dout_en_vec_c, dout_eop_vec_c;
  logic                  grant_load, beat_c, eop_c, err_c;

  assign owner_oh = NUM_REQ'(1) << grant_id;

  // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = 0;
    req_bit = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand    = (32'(rr_ptr) + i) % NUM_REQ;
      req_bit = bus.req_vec >> cand;
      if (!found && req_bit[0]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(cand);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, beat routing to the owner and protocol-error detection.
  always_comb begin
    state_next     = state;
    grant_load     = 1'b0;
    beat_c         = 1'b0;
    eop_c          = 1'b0;
    err_c          = 1'b0;
    ack_vec_c      = '0;
    dout_en_vec_c  = '0;
    dout_eop_vec_c = '0;
    unique case (state)
      IDLE: begin
        err_c = bus.dma_engineer_dout_en | bus.dma_engineer_ack;
        if (found) begin
          grant_load = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.dma_engineer_ack) begin
          ack_vec_c  = owner_oh;
          beat_c     = bus.dma_engineer_dout_en;
          eop_c      = bus.dma_engineer_dout_en & bus.dma_engineer_dout_eop;
          state_next = eop_c ? IDLE : XFER;
        end else begin
          err_c = bus.dma_engineer_dout_en;
        end
      end
      XFER: begin
        err_c  = bus.dma_engineer_ack;
        beat_c = bus.dma_engineer_dout_en;
        eop_c  = bus.dma_engineer_dout_en & bus.dma_engineer_dout_eop;
        if (eop_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (beat_c) dout_en_vec_c  = owner_oh;
    if (eop_c)  dout_eop_vec_c = owner_oh;
  end

  // Grant capture, DMA request, beat counter, round-robin pointer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      start_addr <= '0;
      length     <= '0;
      beat_cnt   <= '0;
      dma_req    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (grant_load) begin
        grant_id   <= winner;
        start_addr <= ADDR_WIDTH'(bus.req_start_addr >> (32'(winner) * ADDR_WIDTH));
        length     <= ADDR_WIDTH'(bus.req_length >> (32'(winner) * ADDR_WIDTH));
        beat_cnt   <= '0;
        dma_req    <= 1'b1;
      end
      if (state == REQ && bus.dma_engineer_ack) dma_req <= 1'b0;
      if (beat_c) beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
      if (eop_c) begin
        rr_ptr <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_WIDTH'(1);
      end
      if (err_c) proto_err <= 1'b1;
    end
  end

  assign bus.ack_vec                 = ack_vec_c;
  assign bus.dout_en_vec             = dout_en_vec_c;
  assign bus.dout_eop_vec            = dout_eop_vec_c;
  assign bus.dout                    = bus.dma_engineer_dout;
  assign bus.dma_engineer_req        = dma_req;
  assign bus.dma_engineer_start_addr = start_addr;
  assign bus.dma_engineer_length     = length;
  assign bus.busy                    = (state != IDLE);
  assign bus.grant_id                = grant_id;
  assign bus.beat_cnt                = beat_cnt;
  assign bus.proto_err               = proto_err;
endmodule

// File: doc/dma_engineer_arbiter.md
Name: dma_engineer_arbiter

Overview:
- Shares one DMA engine (weight-fetch master) among NUM_REQ layer controllers, e.g. the conv/fc layer controllers that each drive a dma_engineer req/ack/dout interface.
- Round-robin arbitration. The grant is held from request until end-of-packet (dout_eop).
- Start address and length are forwarded from the winning requester.
- DMA data-valid and eop are routed back only to the granted requester. DMA data is broadcast to all requesters.

Parameters:
- NUM_REQ, 4, number of requesting layers (2..8).
- ADDR_WIDTH, 27, width of start_addr and length.
- DATA_WIDTH, 512, width of DMA data.
- ID_WIDTH, 2, width of grant_id; must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_vec  in  NUM_REQ  per-requester dma request (level).
- req_start_addr  in  NUM_REQ*ADDR_WIDTH  packed start addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_length  in  NUM_REQ*ADDR_WIDTH  packed lengths, same packing.
- ack_vec  out  NUM_REQ  per-requester ack pulse.
- dout_en_vec  out  NUM_REQ  per-requester data valid.
- dout_eop_vec  out  NUM_REQ  per-requester end of packet.
- dout  out  DATA_WIDTH  DMA data, broadcast to all requesters.
- dma_engineer_req  out  1  request to DMA engine.
- dma_engineer_ack  in  1  DMA accept pulse.
- dma_engineer_start_addr  out  ADDR_WIDTH  forwarded start address.
- dma_engineer_length  out  ADDR_WIDTH  forwarded length.
- dma_engineer_dout_en  in  1  DMA data valid.
- dma_engineer_dout_eop  in  1  DMA last beat.
- dma_engineer_dout  in  DATA_WIDTH  DMA data.
- busy  out  1  state != IDLE.
- grant_id  out  ID_WIDTH  index of current owner; valid while busy.
- beat_cnt  out  ADDR_WIDTH  beats delivered in the current transfer.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset: state=IDLE, rr_ptr=0 (requester 0 highest priority).
  - Outputs: dma_engineer_req=0, start_addr=0, length=0, grant_id=0, beat_cnt=0, proto_err=0, busy=0.
  - ack_vec, dout_en_vec, dout_eop_vec all 0.
  - Reset mid-transfer abandons the grant immediately. Beats arriving after reset are dropped and flag proto_err. The DMA engine is reset together with this block.
- States: IDLE, REQ, XFER.
- IDLE:
  - If any req_vec bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Next cycle: register grant_id, start_addr and length from the winner; set dma_engineer_req=1; go to REQ.
  - Latency from req to dma_engineer_req is 1 cycle.
- REQ:
  - dma_engineer_req, start_addr and length are held stable.
  - On dma_engineer_ack: ack_vec[grant_id]=1 in the same cycle (combinational); dma_engineer_req deasserts on the next cycle; go to XFER.
  - If dma_engineer_dout_en and dout_eop arrive in the same cycle as ack, they are routed, beat_cnt is updated, and the next state is IDLE.
- XFER:
  - dout_en_vec[grant_id] = dma_engineer_dout_en.
  - dout_eop_vec[grant_id] = dma_engineer_dout_en & dma_engineer_dout_eop.
  - All other bits are 0. Routing is combinational, with zero added latency.
  - beat_cnt increments per valid beat; it clears to 0 on the IDLE→REQ transition.
  - On a valid eop: rr_ptr = (grant_id+1) mod NUM_REQ; go to IDLE.
- Back-to-back: a request pending at eop is granted in the IDLE cycle after eop. Minimum gap between transfers is 1 IDLE cycle.
- Request timing:
  - Requests arriving during REQ or XFER wait; they are never pre-empted.
  - A requester must hold req, addr and length until its ack. A deasserted req in REQ does not cancel the DMA request (already issued).
  - Requesters drop req on the cycle after ack. The arbiter ignores req_vec outside IDLE, so a requester holding req past ack is re-granted by round-robin order.
- proto_err is set (sticky until rst) on:
  - dma_engineer_dout_en in IDLE;
  - dma_engineer_dout_en in REQ without ack in the same cycle;
  - dma_engineer_ack outside REQ.
  Offending beats are not routed anywhere.
- Only one ack_vec, dout_en_vec or dout_eop_vec bit may be high in any cycle (one-hot-or-zero).
- rr_ptr wraps from NUM_REQ-1 to 0. Requester indices ≥ NUM_REQ are never granted.

Test Plan:
- Single requester: req_vec=0001, addr=0x100, len=200; DMA acks 3 cycles later and sends 200 beats, eop on the last.
  - Required: dma_engineer_req 1 cycle after req, addr=0x100, len=200.
  - Required: ack_vec=0001; 200 dout_en_vec[0] pulses; beat_cnt=200; one dout_eop_vec[0]; busy low 1 cycle after eop.
- Simultaneous req_vec=0011 with lengths 4 and 8: requester 0 is served first (4 beats), then requester 1 (8 beats), with exactly 1 IDLE cycle between transfers. dout_en_vec[1] stays 0 during transfer 0.
- All four requesters held continuously, each re-requesting after eop: grant order 0,1,2,3,0,1. rr_ptr wraps after requester 3.
- Requester 2 raises req mid-transfer of requester 0: no change to the current transfer; requester 2 is granted the cycle after requester 0's eop.
- ack, dout_en and eop in the same cycle (length 1): ack_vec and dout_eop_vec pulse for the owner in that cycle; next state IDLE; beat_cnt=1.
- Error and reset: dout_en pulse while IDLE → proto_err=1 and no dout_en_vec bit set. Then assert rst mid-XFER (beat 5 of 10) → all outputs return to reset values next cycle, proto_err cleared, and the next request is granted starting from requester 0.
